// File: rtl/reg_write_port.sv
// Write-side port controller for the 16 x 16-bit register file.
// Buffers write-back requests in a small in-order queue and drains one per cycle
// as a registered one-hot wordline strobe. Exposes a pending-write mask and a
// newest-value lookup so the decode stage can detect hazards and bypass.
module reg_write_port #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req_valid,
  output logic              wr_req_ready,
  input  logic [3:0]        wr_req_reg,
  input  logic [DATA_W-1:0] wr_req_data,
  input  logic              stall,
  output logic              WriteEnable,
  output logic [15:0]       WriteWordline,
  output logic [DATA_W-1:0] WriteData,
  output logic [15:0]       pend_mask,
  input  logic [3:0]        lookup_reg,
  output logic              lookup_hit,
  output logic [DATA_W-1:0] lookup_data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [3:0]        q_reg  [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              accept, push, pop;
  logic [PTR_W-1:0]  idx;

  // Ready ignores stall and any same-cycle pop so it never forms a comb path
  assign wr_req_ready = !rst && (count_q < CNT_W'(DEPTH));
  assign accept       = wr_req_valid && wr_req_ready;
  // Register 0 is hard-wired zero: acknowledge but drop the request
  assign push         = accept && (wr_req_reg != 4'd0);
  assign pop          = (count_q != '0) && !stall;

  // Queue storage; entries beyond count are never read, so no reset is needed
  always_ff @(posedge clk) begin
    if (push) begin
      q_reg[wr_ptr_q]  <= wr_req_reg;
      q_data[wr_ptr_q] <= wr_req_data;
    end
  end

  // Pointers, occupancy and the registered drive stage
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      WriteEnable   <= 1'b0;
      WriteWordline <= '0;
      WriteData     <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q      <= rd_ptr_q + PTR_W'(1);
        WriteEnable   <= 1'b1;
        WriteWordline <= 16'h0001 << q_reg[rd_ptr_q];
        WriteData     <= q_data[rd_ptr_q];
      end else begin
        // WriteData deliberately holds its last value
        WriteEnable   <= 1'b0;
        WriteWordline <= '0;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Pending mask and bypass lookup; walking oldest to newest lets the newest match win,
  // and the drive stage is seeded first so any queued match overrides it
  always_comb begin
    pend_mask   = WriteEnable ? WriteWordline : '0;
    lookup_hit  = 1'b0;
    lookup_data = '0;
    idx         = '0;
    if (WriteEnable && WriteWordline[lookup_reg]) begin
      lookup_hit  = 1'b1;
      lookup_data = WriteData;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PTR_W'(i);
      if (CNT_W'(i) < count_q) begin
        pend_mask[q_reg[idx]] = 1'b1;
        if (q_reg[idx] == lookup_reg) begin
          lookup_hit  = 1'b1;
          lookup_data = q_data[idx];
        end
      end
    end
    if (lookup_reg == 4'd0) begin
      lookup_hit  = 1'b0;
      lookup_data = '0;
    end
  end

endmodule

// File: tb/tb_reg_write_port.sv
// Directed bench for reg_write_port: a per-cycle vector table plus hand-written
// streaming and mid-stream reset sequences.
module tb_reg_write_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_req_valid;
  logic        wr_req_ready;
  logic [3:0]  wr_req_reg;
  logic [15:0] wr_req_data;
  logic        stall;
  logic        WriteEnable;
  logic [15:0] WriteWordline;
  logic [15:0] WriteData;
  logic [15:0] pend_mask;
  logic [3:0]  lookup_reg;
  logic        lookup_hit;
  logic [15:0] lookup_data;

  int checks   = 0;
  int failures = 0;

  reg_write_port #(
    .DATA_W(16),
    .DEPTH (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_req_valid (wr_req_valid),
    .wr_req_ready (wr_req_ready),
    .wr_req_reg   (wr_req_reg),
    .wr_req_data  (wr_req_data),
    .stall        (stall),
    .WriteEnable  (WriteEnable),
    .WriteWordline(WriteWordline),
    .WriteData    (WriteData),
    .pend_mask    (pend_mask),
    .lookup_reg   (lookup_reg),
    .lookup_hit   (lookup_hit),
    .lookup_data  (lookup_data)
  );

  always #5 clk = ~clk;

  // One row per cycle: inputs driven after the falling edge, outputs checked 1ns later
  typedef struct {
    logic        rst;
    logic        v;
    logic [3:0]  rg;
    logic [15:0] dat;
    logic        st;
    logic [3:0]  lk;
    logic        rdy;
    logic        we;
    logic [15:0] wl;
    logic [15:0] wd;
    logic [15:0] pm;
    logic        hit;
    logic [15:0] ld;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic v, input logic [3:0] rg, input logic [15:0] dat,
                     input logic st, input logic [3:0] lk, input logic rdy, input logic we,
                     input logic [15:0] wl, input logic [15:0] wd, input logic [15:0] pm,
                     input logic hit, input logic [15:0] ld);
    vec_t t;
    t.rst = r;  t.v = v;   t.rg = rg; t.dat = dat; t.st = st; t.lk = lk;
    t.rdy = rdy; t.we = we; t.wl = wl; t.wd = wd;  t.pm = pm; t.hit = hit; t.ld = ld;
    vecs.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [3:0] rg,
                       input logic [15:0] dat, input logic st, input logic [3:0] lk);
    rst = r; wr_req_valid = v; wr_req_reg = rg; wr_req_data = dat; stall = st; lookup_reg = lk;
  endtask

  initial begin
    drive(1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
    repeat (2) @(posedge clk);

    //   rst v  rg     dat      st  lk     rdy we wl        wd       pm       hit ld
    // Reset with a request present: ignored
    add(1, 1, 4'd5,  16'hBEEF, 0, 4'd5,  0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000);
    // Single write to reg 5
    add(0, 1, 4'd5,  16'hBEEF, 0, 4'd5,  1, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000);
    add(0, 0, 4'd5,  16'h0000, 0, 4'd5,  1, 0, 16'h0000, 16'h0000, 16'h0020, 1, 16'hBEEF);
    add(0, 0, 4'd5,  16'h0000, 0, 4'd5,  1, 1, 16'h0020, 16'hBEEF, 16'h0020, 1, 16'hBEEF);
    add(0, 0, 4'd5,  16'h0000, 0, 4'd5,  1, 0, 16'h0000, 16'hBEEF, 16'h0000, 0, 16'h0000);
    // R0 discard
    add(0, 1, 4'd0,  16'h1234, 0, 4'd0,  1, 0, 16'h0000, 16'hBEEF, 16'h0000, 0, 16'h0000);
    add(0, 0, 4'd0,  16'h0000, 0, 4'd0,  1, 0, 16'h0000, 16'hBEEF, 16'h0000, 0, 16'h0000);
    add(0, 0, 4'd0,  16'h0000, 0, 4'd0,  1, 0, 16'h0000, 16'hBEEF, 16'h0000, 0, 16'h0000);
    // Fill under stall, newest wins, full blocks even with a pop
    add(0, 1, 4'd3,  16'h0001, 1, 4'd3,  1, 0, 16'h0000, 16'hBEEF, 16'h0000, 0, 16'h0000);
    add(0, 1, 4'd3,  16'h0002, 1, 4'd3,  1, 0, 16'h0000, 16'hBEEF, 16'h0008, 1, 16'h0001);
    add(0, 1, 4'd7,  16'h7777, 1, 4'd3,  0, 0, 16'h0000, 16'hBEEF, 16'h0008, 1, 16'h0002);
    add(0, 1, 4'd7,  16'h7777, 0, 4'd3,  0, 0, 16'h0000, 16'hBEEF, 16'h0008, 1, 16'h0002);
    add(0, 1, 4'd7,  16'h7777, 0, 4'd3,  1, 1, 16'h0008, 16'h0001, 16'h0008, 1, 16'h0002);
    add(0, 0, 4'd0,  16'h0000, 0, 4'd7,  1, 1, 16'h0008, 16'h0002, 16'h0088, 1, 16'h7777);
    add(0, 0, 4'd0,  16'h0000, 0, 4'd3,  1, 1, 16'h0080, 16'h7777, 16'h0080, 0, 16'h0000);
    add(0, 0, 4'd0,  16'h0000, 0, 4'd7,  1, 0, 16'h0000, 16'h7777, 16'h0000, 0, 16'h0000);
    // Drive-stage lookup on reg 9, then empty with stall
    add(0, 1, 4'd9,  16'h00AA, 0, 4'd9,  1, 0, 16'h0000, 16'h7777, 16'h0000, 0, 16'h0000);
    add(0, 0, 4'd0,  16'h0000, 0, 4'd9,  1, 0, 16'h0000, 16'h7777, 16'h0200, 1, 16'h00AA);
    add(0, 0, 4'd0,  16'h0000, 0, 4'd9,  1, 1, 16'h0200, 16'h00AA, 16'h0200, 1, 16'h00AA);
    add(0, 0, 4'd0,  16'h0000, 1, 4'd9,  1, 0, 16'h0000, 16'h00AA, 16'h0000, 0, 16'h0000);
    // Stall after first pop: strobe drops after one cycle, queue holds
    add(0, 1, 4'd10, 16'h0A0A, 0, 4'd10, 1, 0, 16'h0000, 16'h00AA, 16'h0000, 0, 16'h0000);
    add(0, 1, 4'd11, 16'h0B0B, 1, 4'd10, 1, 0, 16'h0000, 16'h00AA, 16'h0400, 1, 16'h0A0A);
    add(0, 0, 4'd0,  16'h0000, 0, 4'd11, 0, 0, 16'h0000, 16'h00AA, 16'h0C00, 1, 16'h0B0B);
    add(0, 0, 4'd0,  16'h0000, 1, 4'd10, 1, 1, 16'h0400, 16'h0A0A, 16'h0C00, 1, 16'h0A0A);
    add(0, 0, 4'd0,  16'h0000, 1, 4'd10, 1, 0, 16'h0000, 16'h0A0A, 16'h0800, 0, 16'h0000);
    add(0, 0, 4'd0,  16'h0000, 0, 4'd11, 1, 0, 16'h0000, 16'h0A0A, 16'h0800, 1, 16'h0B0B);
    add(0, 0, 4'd0,  16'h0000, 0, 4'd11, 1, 1, 16'h0800, 16'h0B0B, 16'h0800, 1, 16'h0B0B);
    add(0, 0, 4'd0,  16'h0000, 0, 4'd11, 1, 0, 16'h0000, 16'h0B0B, 16'h0000, 0, 16'h0000);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].v, vecs[i].rg, vecs[i].dat, vecs[i].st, vecs[i].lk);
      #1;
      chk($sformatf("row%0d_ready", i), 32'(wr_req_ready),  32'(vecs[i].rdy));
      chk($sformatf("row%0d_we", i),    32'(WriteEnable),   32'(vecs[i].we));
      chk($sformatf("row%0d_wl", i),    32'(WriteWordline), 32'(vecs[i].wl));
      chk($sformatf("row%0d_wd", i),    32'(WriteData),     32'(vecs[i].wd));
      chk($sformatf("row%0d_pend", i),  32'(pend_mask),     32'(vecs[i].pm));
      chk($sformatf("row%0d_hit", i),   32'(lookup_hit),    32'(vecs[i].hit));
      chk($sformatf("row%0d_ldata", i), 32'(lookup_data),   32'(vecs[i].ld));
    end

    // Streaming regs 1..8: strobe for reg k appears in cycle k+1
    for (int c = 0; c < 12; c++) begin
      logic        exp_we;
      logic [15:0] exp_wl, exp_wd;
      @(negedge clk);
      drive(1'b0, c < 8, 4'(c + 1), 16'h1000 + 16'(c + 1), 1'b0, 4'd0);
      #1;
      exp_we = (c >= 2) && (c <= 9);
      exp_wl = exp_we ? (16'h0001 << (c - 1)) : 16'h0000;
      exp_wd = (c >= 2) ? 16'h1000 + 16'((c <= 9) ? c - 1 : 8) : 16'h0B0B;
      if (c < 8) chk($sformatf("stream%0d_ready", c), 32'(wr_req_ready), 32'd1);
      chk($sformatf("stream%0d_we", c), 32'(WriteEnable),   32'(exp_we));
      chk($sformatf("stream%0d_wl", c), 32'(WriteWordline), 32'(exp_wl));
      chk($sformatf("stream%0d_wd", c), 32'(WriteData),     32'(exp_wd));
    end

    // Mid-stream reset: queue two writes under stall, then reset for one edge
    @(negedge clk);
    drive(1'b0, 1'b1, 4'd4, 16'h4444, 1'b1, 4'd4);
    @(negedge clk);
    drive(1'b0, 1'b1, 4'd6, 16'h6666, 1'b1, 4'd6);
    @(negedge clk);
    drive(1'b1, 1'b1, 4'd2, 16'h2222, 1'b0, 4'd6);
    #1;
    chk("rstseq_pend_before", 32'(pend_mask),    32'h0050);
    chk("rstseq_ready_in_rst", 32'(wr_req_ready), 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, (c % 2 == 0) ? 4'd4 : 4'd6);
      #1;
      chk($sformatf("rstseq%0d_we", c),    32'(WriteEnable),   32'd0);
      chk($sformatf("rstseq%0d_wl", c),    32'(WriteWordline), 32'd0);
      chk($sformatf("rstseq%0d_wd", c),    32'(WriteData),     32'd0);
      chk($sformatf("rstseq%0d_pend", c),  32'(pend_mask),     32'd0);
      chk($sformatf("rstseq%0d_hit", c),   32'(lookup_hit),    32'd0);
      chk($sformatf("rstseq%0d_ready", c), 32'(wr_req_ready),  32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
